// File: rtl/issue_scheduler_pkg.sv
// tomasulo_pkg: shared opcodes, instruction fields, sizing and tag mapping for the issue stage
package tomasulo_pkg;
  localparam int TAG_W = 3;
  localparam int N_ADD = 3;
  localparam int N_MUL = 2;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam int OP_LSB = 0;
  localparam int RT_LSB = 4;
  localparam int RS_LSB = 7;
  localparam int RD_LSB = 10;
  typedef enum logic {EMPTY, HELD} state_t;
  function automatic logic [TAG_W-1:0] rs_tag(input int idx);
    return TAG_W'(idx + 1);
  endfunction
endpackage

// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if: queue, release, CDB and dispatch signals of the issue stage
interface issue_scheduler_if #(
  parameter int N_ADD = tomasulo_pkg::N_ADD,
  parameter int N_MUL = tomasulo_pkg::N_MUL,
  parameter int TAG_W = tomasulo_pkg::TAG_W
);
  logic instValid;
  logic [15:0] instruction;
  logic avaliable;
  logic [N_ADD+N_MUL-1:0] rsFree;
  logic cdbValid;
  logic [TAG_W-1:0] cdbTag;
  logic issueValid;
  logic [TAG_W-1:0] issueTag;
  logic [3:0] issueOp;
  logic [2:0] issueRd;
  logic [2:0] issueRs;
  logic [2:0] issueRt;
  logic [TAG_W-1:0] issueQj;
  logic [TAG_W-1:0] issueQk;
  logic illegalOp;
  modport master (
    output instValid, instruction, rsFree, cdbValid, cdbTag,
    input avaliable, issueValid, issueTag, issueOp, issueRd, issueRs, issueRt, issueQj, issueQk, illegalOp
  );
  modport slave (
    input instValid, instruction, rsFree, cdbValid, cdbTag,
    output avaliable, issueValid, issueTag, issueOp, issueRd, issueRs, issueRt, issueQj, issueQk, illegalOp
  );
endinterface

// File: rtl/rs_allocator.sv
// rs_allocator: busy bits for all RSs and lowest-free-index pick within the requested class
module rs_allocator #(
  parameter int N_ADD = tomasulo_pkg::N_ADD,
  parameter int N_MUL = tomasulo_pkg::N_MUL,
  parameter int TAG_W = tomasulo_pkg::TAG_W
) (
  input  logic Clock,
  input  logic Reset,
  input  logic isMul,
  input  logic alloc,
  input  logic [N_ADD+N_MUL-1:0] rsFree,
  output logic free,
  output logic [TAG_W-1:0] tag
);
  import tomasulo_pkg::*;
  localparam int N_RS = N_ADD + N_MUL;
  logic [N_RS-1:0] busy, pick;
  // scan downward so the lowest free slot of the class is the last one written
  always_comb begin
    pick = '0;
    tag = '0;
    for (int i = N_RS - 1; i >= 0; i--)
      if (((i >= N_ADD) == isMul) && !busy[i]) begin
        pick = N_RS'(1) << i;
        tag = rs_tag(i);
      end
  end
  assign free = |pick;
  // releases land at the edge and are seen by allocation only in the next cycle
  always_ff @(posedge Clock)
    busy <= Reset ? '0 : (busy & ~rsFree) | (alloc ? pick : '0);
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: holds one instruction, allocates an RS, renames rd and dispatches with source tags
module issue_scheduler #(
  parameter int N_ADD = tomasulo_pkg::N_ADD,
  parameter int N_MUL = tomasulo_pkg::N_MUL,
  parameter int TAG_W = tomasulo_pkg::TAG_W
) (
  input logic Clock,
  input logic Reset,
  issue_scheduler_if.slave bus
);
  import tomasulo_pkg::*;
  state_t state;
  logic [15:0] hold;
  logic [TAG_W-1:0] reg_stat [8];
  logic [3:0] op;
  logic [2:0] rd, rs, rt;
  logic is_mul, legal, class_free, issue_now, accept;
  logic [TAG_W-1:0] tag, qj, qk;
  assign op = hold[OP_LSB +: 4];
  assign rd = hold[RD_LSB +: 3];
  assign rs = hold[RS_LSB +: 3];
  assign rt = hold[RT_LSB +: 3];
  assign is_mul = op == OP_MUL;
  assign legal = is_mul || op == OP_ADD || op == OP_SUB;
  assign issue_now = state == HELD && legal && class_free;
  assign bus.avaliable = state == EMPTY || issue_now;
  assign accept = bus.instValid && bus.avaliable;
  assign qj = (bus.cdbValid && bus.cdbTag == reg_stat[rs]) ? '0 : reg_stat[rs];
  assign qk = (bus.cdbValid && bus.cdbTag == reg_stat[rt]) ? '0 : reg_stat[rt];
  rs_allocator #(.N_ADD(N_ADD), .N_MUL(N_MUL), .TAG_W(TAG_W)) u_alloc (
    .Clock(Clock),
    .Reset(Reset),
    .isMul(is_mul),
    .alloc(issue_now),
    .rsFree(bus.rsFree),
    .free(class_free),
    .tag(tag)
  );
  // hold/issue FSM, register-status table and registered dispatch outputs; the rd rename beats a same-cycle CDB clear
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= EMPTY;
      hold <= '0;
      reg_stat <= '{default: '0};
      bus.issueValid <= 1'b0;
      bus.illegalOp <= 1'b0;
      bus.issueTag <= '0;
      bus.issueOp <= '0;
      bus.issueRd <= '0;
      bus.issueRs <= '0;
      bus.issueRt <= '0;
      bus.issueQj <= '0;
      bus.issueQk <= '0;
    end else begin
      bus.issueValid <= issue_now;
      bus.illegalOp <= state == HELD && !legal;
      if (issue_now) begin
        bus.issueTag <= tag;
        bus.issueOp <= op;
        bus.issueRd <= rd;
        bus.issueRs <= rs;
        bus.issueRt <= rt;
        bus.issueQj <= qj;
        bus.issueQk <= qk;
      end
      for (int r = 0; r < 8; r++)
        reg_stat[r] <= (issue_now && rd == 3'(r)) ? tag : (bus.cdbValid && bus.cdbTag == reg_stat[r]) ? '0 : reg_stat[r];
      if (accept) hold <= bus.instruction;
      state <= accept ? HELD : (state == HELD && (issue_now || !legal)) ? EMPTY : state;
    end
  end
endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Tomasulo issue stage between the instruction queue and the reservation stations (RS). Takes one 16-bit instruction at a time from the queue, decodes it and allocates a free RS of the right class. It also renames the destination register in an internal register-status table and dispatches the instruction with source tags. It tracks RS occupancy, and snoops the common data bus (CDB) to clear completed tags.

## Interface
Parameters:
- `N_ADD`, 3: add/sub reservation stations, tags 1..N_ADD
- `N_MUL`, 2: multiply reservation stations, tags N_ADD+1..N_ADD+N_MUL
- `TAG_W`, 3: tag width; tag 0 = "value ready, no producer"

Ports:
- `Clock`  in  1  single clock, all state on posedge
- `Reset`  in  1  synchronous, active-high
- `instValid`  in  1  queue presents a valid instruction
- `instruction`  in  16  [12:10] rd, [9:7] rs, [6:4] rt, [3:0] op; [15:13] ignored
- `avaliable`  out  1  scheduler can accept an instruction this cycle
- `rsFree`  in  N_ADD+N_MUL  one-hot-per-bit release pulses; bit i frees tag i+1
- `cdbValid`  in  1  CDB broadcast valid
- `cdbTag`  in  TAG_W  tag being broadcast
- `issueValid`  out  1  one-cycle dispatch strobe
- `issueTag`  out  TAG_W  allocated RS tag
- `issueOp`  out  4  opcode
- `issueRd`, `issueRs`, `issueRt`  out  3 each  register indices
- `issueQj`, `issueQk`  out  TAG_W  producer tags of rs/rt; 0 = read register file
- `illegalOp`  out  1  one-cycle pulse, unsupported opcode consumed

## Operation
- Opcodes: ADD=4'b0000 and SUB=4'b0001 use the add class; MUL=4'b0100 uses the mul class. Any other opcode is illegal.
- State machine:
  - EMPTY: no instruction held.
  - HELD: one instruction latched in the hold register.
- Class-free check: at least one busy bit of the instruction's class is clear. Allocation picks the lowest free index in that class.
- `issueNow` = HELD and the held op is legal and its class has a free RS.
- `avaliable` = EMPTY or `issueNow`. It is combinational from state and busy bits.
- Accept: `instValid & avaliable` at posedge latches the instruction and moves to HELD.
- Issue at posedge when `issueNow`:
  - register all issue outputs and assert `issueValid`;
  - set the busy bit for the allocated tag;
  - write `regStat[rd] = tag`;
  - go to EMPTY, or stay in HELD if a new instruction was accepted in the same cycle.
- Illegal op in HELD: drop it the next cycle, pulse `illegalOp`, and go to EMPTY. The scheduler does not accept a new instruction that cycle.
- Stall: HELD with the class full means hold indefinitely. Outputs keep `issueValid=0`.
- Source tags: `Qj = regStat[rs]`, forced to 0 if `cdbValid` and `cdbTag == regStat[rs]` in the issue cycle. `Qk` follows the same rule with rt.
- CDB: on `cdbValid`, every `regStat` entry equal to `cdbTag` is cleared to 0. The rd entry written by a simultaneous issue keeps the new tag, because issue wins.
- rs == rt, or rd == rs/rt: source tags are read before the rd rename. For ADD R6,R5,R5, Qj and Qk come from the old `regStat[5]`, and `regStat[6]` then gets the new tag.
- Release: an `rsFree` bit clears the busy bit at posedge and is visible to allocation next cycle, with no bypass. A release for an already-free slot is ignored. Release and CDB on the same cycle are independent.

## Timing
- Reset values:
  - state EMPTY, all busy bits 0, all `regStat` 0;
  - `issueValid=0`, `illegalOp=0`;
  - all issue fields 0;
  - `avaliable=1` in the cycle after `Reset` deasserts.
- Reset asserted mid-operation discards the held instruction and all tags with no issue pulse.
- Latency: accept edge to `issueValid` high is 1 cycle when a free RS exists.
- Throughput: 1 instruction per cycle while RSs are available.
- `issueValid` is high for exactly one cycle per issued instruction. The fields are valid only while it is high.

## Structure
- Shared package `tomasulo_pkg` holds:
  - opcode constants OP_ADD, OP_SUB, OP_MUL;
  - instruction field positions;
  - TAG_W, N_ADD, N_MUL;
  - a function mapping RS index to tag.
- Sub-module `rs_allocator`: lowest-free-index priority encoder per class, with busy-bit register and set/clear logic.
- The register-status table (8 × TAG_W) and the FSM live in `issue_scheduler`.

## Test plan
- Reset, then ADD R3,R1,R2 (16'b0000110010100000) → next cycle `issueValid=1`, tag 1, Qj=0, Qk=0; `regStat[3]=1`.
- Then SUB R5,R3,R1 → tag 2, Qj=1, Qk=0; with `cdbValid`, `cdbTag=1` in that issue cycle → Qj=0.
- Four back-to-back ADDs with no `rsFree` → tags 1,2,3 issued; 4th stalls with `avaliable=0`. Pulse `rsFree[1]` → 4th issues with tag 2 one cycle later.
- Three MULs → tags 4,5, then stall. A concurrent ADD after the stalled MUL waits behind it, because there is no bypass of the hold register.
- Issue MUL R6 (tag 4) while `cdbTag=4` clears an older R6 entry → `regStat[6]=4` retained.
- Opcode 4'b1111 → `illegalOp` pulse, no `issueValid`, no state change. `Reset` asserted during a stall → all busy bits 0 and `avaliable=1` after release.
